// File: rtl/spi_fword_pkg.sv
//------------------------------------------------------------------------------
// spi_fword_pkg
// Shared definitions for the framed SPI frequency-word loader: header codes,
// frame-parser state encoding and a constant-width helper.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package spi_fword_pkg;

    localparam logic [3:0] HDR_WRITE  = 4'hA;
    localparam logic [7:0] HDR_COMMIT = 8'hB0;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK
    } state_t;

    // Ceiling log2, used for index and timeout counter widths
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/spi_frame_parser.sv
//------------------------------------------------------------------------------
// spi_frame_parser
// Parses the framed byte stream (write frame: 0xA0|ch, payload LSB first,
// XOR checksum; commit frame: 0xB0 0xB0) and enforces the inter-byte timeout.
// Outcome strobes are decoded in the cycle the checksum byte (or timeout)
// is seen; the top registers them.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_rx_valid/i_rx_data received byte strobe and data
//   o_wr_ok, o_ch, o_word  accepted write frame, channel and assembled word
//   o_commit_ok         accepted commit frame
//   o_err               rejected frame (checksum, channel, timeout)
//   o_busy              frame in progress
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_frame_parser
    import spi_fword_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned FW_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYC = 30000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rx_valid,
    input  logic [7:0]          i_rx_data,
    output logic                o_wr_ok,
    output logic [3:0]          o_ch,
    output logic [FW_WIDTH-1:0] o_word,
    output logic                o_commit_ok,
    output logic                o_err,
    output logic                o_busy
);

    localparam int unsigned NB    = FW_WIDTH / 8;
    localparam int unsigned IDX_W = (NB > 1) ? clog2(NB) : 1;
    localparam int unsigned TO_W  = clog2(TIMEOUT_CYC + 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_cks;
    logic [3:0]          r_ch;
    logic                r_commit;
    logic [FW_WIDTH-1:0] r_asm;
    logic [TO_W-1:0]     r_gap;

    logic w_timeout;
    logic w_check_byte;
    logic w_match;
    logic w_ch_ok;
    logic w_wr_ok;
    logic w_commit_ok;

    // A byte arriving in the expiry cycle suppresses the timeout
    assign w_timeout    = (r_state != IDLE) && !i_rx_valid &&
                          (r_gap == TO_W'(TIMEOUT_CYC - 1));
    assign w_check_byte = (r_state == CHECK) && i_rx_valid;
    assign w_match      = (i_rx_data == r_cks);
    assign w_ch_ok      = ({1'b0, r_ch} < 5'(NCH));
    assign w_wr_ok      = w_check_byte && w_match && !r_commit && w_ch_ok;
    assign w_commit_ok  = w_check_byte && w_match && r_commit;

    assign o_wr_ok     = w_wr_ok;
    assign o_commit_ok = w_commit_ok;
    assign o_err       = w_timeout || (w_check_byte && !(w_wr_ok || w_commit_ok));
    assign o_ch        = r_ch;
    assign o_word      = r_asm;
    assign o_busy      = (r_state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cks    <= '0;
            r_ch     <= '0;
            r_commit <= 1'b0;
            r_asm    <= '0;
            r_gap    <= '0;
        end else begin
            if (i_rx_valid)
                r_gap <= '0;
            else if (r_state != IDLE)
                r_gap <= r_gap + 1'b1;

            case (r_state)
                IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data[7:4] == HDR_WRITE) begin
                            r_state  <= PAYLOAD;
                            r_ch     <= i_rx_data[3:0];
                            r_idx    <= '0;
                            r_cks    <= i_rx_data;
                            r_commit <= 1'b0;
                        end else if (i_rx_data == HDR_COMMIT) begin
                            r_state  <= CHECK;
                            r_cks    <= i_rx_data;
                            r_commit <= 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                    end else if (i_rx_valid) begin
                        for (int unsigned b = 0; b < NB; b++)
                            if (r_idx == IDX_W'(b))
                                r_asm[b*8 +: 8] <= i_rx_data;
                        r_cks <= r_cks ^ i_rx_data;
                        if (r_idx == IDX_W'(NB - 1))
                            r_state <= CHECK;
                        else
                            r_idx <= r_idx + 1'b1;
                    end
                end
                CHECK: begin
                    if (w_timeout || i_rx_valid)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/spi_fword_loader.sv
//------------------------------------------------------------------------------
// spi_fword_loader
// Multi-channel frequency-word loader. Accepted write frames land in per-
// channel shadow registers; a commit frame copies every shadow to its active
// word in one cycle so multi-channel updates stay phase-coherent
// (AUTO_APPLY=1 also applies each write immediately).
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   rx_valid, rx_data   received SPI byte strobe and data
//   fword_o             active words, channel k at [k*FW_WIDTH +: FW_WIDTH]
//   fword_upd           per-channel pulse when the active word changed
//   frame_ok/frame_err  accepted / rejected frame pulse
//   err_cnt             saturating rejected-frame count
//   busy                frame in progress
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_fword_loader
    import spi_fword_pkg::*;
#(
    parameter int unsigned         NCH         = 4,
    parameter int unsigned         FW_WIDTH    = 32,
    parameter int unsigned         TIMEOUT_CYC = 30000,
    parameter bit                  AUTO_APPLY  = 1'b0,
    parameter logic [FW_WIDTH-1:0] RESET_FWORD = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic [NCH*FW_WIDTH-1:0] fword_o,
    output logic [NCH-1:0]          fword_upd,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic [7:0]              err_cnt,
    output logic                    busy
);

    logic                w_wr_ok;
    logic [3:0]          w_ch;
    logic [FW_WIDTH-1:0] w_word;
    logic                w_commit_ok;
    logic                w_err;
    logic                w_busy;

    logic [FW_WIDTH-1:0] r_shadow [NCH];
    logic [FW_WIDTH-1:0] r_active [NCH];
    logic [NCH-1:0]      r_upd;
    logic                r_ok;
    logic                r_err;
    logic [7:0]          r_err_cnt;

    spi_frame_parser #(
        .NCH         (NCH),
        .FW_WIDTH    (FW_WIDTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_parser (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_wr_ok     (w_wr_ok),
        .o_ch        (w_ch),
        .o_word      (w_word),
        .o_commit_ok (w_commit_ok),
        .o_err       (w_err),
        .o_busy      (w_busy)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                r_shadow[k] <= RESET_FWORD;
                r_active[k] <= RESET_FWORD;
            end
            r_upd     <= '0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_ok  <= w_wr_ok || w_commit_ok;
            r_err <= w_err;
            r_upd <= '0;
            if (w_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + 1'b1;
            for (int unsigned k = 0; k < NCH; k++) begin
                if (w_wr_ok && (w_ch == 4'(k))) begin
                    r_shadow[k] <= w_word;
                    if (AUTO_APPLY) begin
                        r_active[k] <= w_word;
                        r_upd[k]    <= (w_word != r_active[k]);
                    end
                end
                if (w_commit_ok) begin
                    r_active[k] <= r_shadow[k];
                    r_upd[k]    <= (r_shadow[k] != r_active[k]);
                end
            end
        end
    end

    always_comb begin
        fword_o = '0;
        for (int unsigned k = 0; k < NCH; k++)
            fword_o[k*FW_WIDTH +: FW_WIDTH] = r_active[k];
    end

    assign fword_upd = r_upd;
    assign frame_ok  = r_ok;
    assign frame_err = r_err;
    assign err_cnt   = r_err_cnt;
    assign busy      = w_busy;

endmodule
